clock_set_ctrl: RTL and testbench
=================================

// Module: clock_set_ctrl
// PURPOSE
//  Time-set sequencer for the digital clock. Consumes one-cycle debounced button pulses
//  (mode/up/down) plus held levels and sequences RUN -> SET_HR -> SET_MIN -> RUN.
//  Issues single-cycle inc/dec strobes to the hour/minute counters, gates the seconds
//  counter, and drives blink and auto-repeat. Sits between the button debouncers and
//  the timekeeping counters.
// PARAMETERS
//  CNT_W         10    width of all tick counters; every tick parameter < 2**CNT_W
//  REPEAT_DELAY  50    ticks a button is held before auto-repeat starts (0.5 s @100 Hz)
//  REPEAT_RATE   10    ticks between auto-repeat strobes
//  TIMEOUT_TICKS 1000  ticks without a button pulse in a set state -> back to RUN
//  BLINK_TICKS   25    ticks per blink half-period
// PORTS
//  clk          in   1  50 MHz system clock
//  rst_n        in   1  asynchronous active-low reset
//  tick         in   1  one-clk-wide strobe at the slow rate (100 Hz)
//  mode_pulse   in   1  debounced one-clk pulse, mode button
//  up_pulse     in   1  debounced one-clk pulse, up button
//  down_pulse   in   1  debounced one-clk pulse, down button
//  up_held      in   1  debounced level, up button
//  down_held    in   1  debounced level, down button
//  run_en       out  1  1 = seconds counter may advance
//  sec_clr      out  1  one-clk pulse: clear seconds
//  hour_inc     out  1  one-clk strobe     hour_dec  out  1  one-clk strobe
//  min_inc      out  1  one-clk strobe     min_dec   out  1  one-clk strobe
//  blink_on     out  1  1 = edited field visible
//  set_state    out  2  00 RUN, 01 SET_HR, 10 SET_MIN
// BEHAVIOUR
//  - All outputs registered; response is 1 clk after the causing input.
//  - Reset (async assert, sync deassert): state RUN, run_en=1, blink_on=1,
//    set_state=00, all strobes/sec_clr=0, all counters 0. Reset mid-edit aborts to RUN.
//  - FSM on mode_pulse: RUN->SET_HR (sec_clr=1 one clk), SET_HR->SET_MIN, SET_MIN->RUN.
//    Encoding 11 is illegal and returns to RUN next clk.
//  - run_en=1 only in RUN. In RUN up/down pulses and held levels are ignored.
//  - SET_HR: up_pulse->hour_inc, down_pulse->hour_dec. SET_MIN: same to min_inc/min_dec.
//  - Simultaneous: mode_pulse wins over up/down in the same clk (no strobe issued);
//    up_pulse and down_pulse together -> no strobe.
//  - Auto-repeat (per button): counts ticks while held, in a set state, other button
//    not held. At count REPEAT_DELAY emit one strobe, then every REPEAT_RATE ticks
//    after. Counter clears on release, state change or both held.
//    Strobe target follows the current state.
//  - Timeout: tick counter in SET_HR/SET_MIN, cleared by any pulse input or state
//    change. Reaching TIMEOUT_TICKS -> RUN next clk; no sec_clr on this exit.
//  - Blink: in set states blink_on toggles every BLINK_TICKS ticks. On entry to a set
//    state the counter clears and blink_on=1. Any inc/dec strobe forces blink_on=1 and
//    clears the counter. In RUN blink_on=1.
//  - Counters saturate, never wrap; all compares are unsigned at CNT_W.
//  - At most one of hour_inc/hour_dec/min_inc/min_dec is high in any clk; a pulse
//    strobe and a repeat strobe in the same clk merge into one.
// STRUCTURE
//  - Package clock_set_pkg: state constants (ST_RUN, ST_SET_HR, ST_SET_MIN) and
//    default tick constants shared with the display blink logic.
//  - Sub-module auto_repeat_gen (tick, held, enable -> strobe, with REPEAT_DELAY,
//    REPEAT_RATE and CNT_W), instanced for up and for down.
//  - FSM, timeout counter and blink counter live in the top module.
// TESTING (bench with REPEAT_DELAY=5, REPEAT_RATE=2, TIMEOUT_TICKS=20, BLINK_TICKS=3)
//  - Reset mid-SET_MIN -> set_state=00, run_en=1, blink_on=1, all strobes 0 immediately.
//  - mode x3 -> set_state 01,10,00; one sec_clr on first; run_en=0 while 01/10.
//  - SET_HR, up_pulse -> hour_inc=1 one clk after; mode+up same clk -> SET_MIN, no strobe.
//  - SET_MIN, up_held for 11 ticks -> min_inc at ticks 5,7,9,11; release -> none.
//  - SET_HR, no buttons for 20 ticks -> set_state=00, sec_clr stays 0.
//  - SET_HR idle -> blink_on toggles every 3 ticks; down_pulse -> hour_dec, blink_on=1.

Source files
------------

// File: rtl/clock_set_pkg.sv
// rtl/clock_set_pkg.sv - shared state encoding and default tick constants for the clock time-set path
package clock_set_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_HR  = 2'b01,
    ST_SET_MIN = 2'b10
  } set_state_t;

  // Tick counts at the 100 Hz slow rate; the display blink logic reuses DEF_BLINK_TICKS.
  localparam int DEF_CNT_W         = 10;
  localparam int DEF_REPEAT_DELAY  = 50;
  localparam int DEF_REPEAT_RATE   = 10;
  localparam int DEF_TIMEOUT_TICKS = 1000;
  localparam int DEF_BLINK_TICKS   = 25;

endpackage

// File: rtl/clock_set_ctrl_if.sv
// rtl/clock_set_ctrl_if.sv - button inputs and counter-control outputs of the time-set sequencer
interface clock_set_ctrl_if;

  logic       tick;
  logic       mode_pulse;
  logic       up_pulse;
  logic       down_pulse;
  logic       up_held;
  logic       down_held;
  logic       run_en;
  logic       sec_clr;
  logic       hour_inc;
  logic       hour_dec;
  logic       min_inc;
  logic       min_dec;
  logic       blink_on;
  logic [1:0] set_state;

  modport master (
    output tick, mode_pulse, up_pulse, down_pulse, up_held, down_held,
    input  run_en, sec_clr, hour_inc, hour_dec, min_inc, min_dec, blink_on, set_state
  );

  modport slave (
    input  tick, mode_pulse, up_pulse, down_pulse, up_held, down_held,
    output run_en, sec_clr, hour_inc, hour_dec, min_inc, min_dec, blink_on, set_state
  );

endinterface

// File: rtl/auto_repeat_gen.sv
// rtl/auto_repeat_gen.sv - held-button auto-repeat: first strobe after REPEAT_DELAY ticks, then every REPEAT_RATE
module auto_repeat_gen #(
  parameter int CNT_W        = 10,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic held,
  input  logic enable,
  output logic strobe
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] target;
  logic             repeating;
  logic             active;

  assign active  = held && enable;
  assign cnt_inc = cnt + {{(CNT_W-1){1'b0}}, (cnt != '1)};
  assign target  = repeating ? CNT_W'(REPEAT_RATE) : CNT_W'(REPEAT_DELAY);

  // Combinational so the top can register it alongside the button-pulse strobes.
  assign strobe  = active && tick && (cnt_inc >= target);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      repeating <= 1'b0;
    end else if (!active) begin
      cnt       <= '0;
      repeating <= 1'b0;
    end else if (strobe) begin
      cnt       <= '0;
      repeating <= 1'b1;
    end else if (tick) begin
      cnt       <= cnt_inc;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - RUN/SET_HR/SET_MIN sequencer driving hour/minute strobes, seconds gating and blink
module clock_set_ctrl
  import clock_set_pkg::*;
#(
  parameter int CNT_W         = DEF_CNT_W,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE   = DEF_REPEAT_RATE,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
  parameter int BLINK_TICKS   = DEF_BLINK_TICKS
) (
  input  logic             clk,
  input  logic             rst_n,
  clock_set_ctrl_if.slave  bus
);

  set_state_t       state;
  set_state_t       state_nx;
  logic             in_set;
  logic             state_chg;
  logic             any_pulse;
  logic             up_rep;
  logic             dn_rep;
  logic             up_req;
  logic             dn_req;
  logic             go_up;
  logic             go_dn;
  logic [CNT_W-1:0] to_cnt;
  logic [CNT_W-1:0] to_inc;
  logic [CNT_W-1:0] bl_cnt;
  logic [CNT_W-1:0] bl_inc;
  logic             to_hit;

  assign in_set    = (state == ST_SET_HR) || (state == ST_SET_MIN);
  assign any_pulse = bus.mode_pulse || bus.up_pulse || bus.down_pulse;
  assign to_inc    = to_cnt + {{(CNT_W-1){1'b0}}, (to_cnt != '1)};
  assign bl_inc    = bl_cnt + {{(CNT_W-1){1'b0}}, (bl_cnt != '1)};
  assign to_hit    = in_set && bus.tick && !any_pulse && (to_inc >= CNT_W'(TIMEOUT_TICKS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nx;
  end

  // Mode always takes priority over the idle timeout.
  always_comb begin
    state_nx = state;
    case (state)
      ST_RUN:     if (bus.mode_pulse) state_nx = ST_SET_HR;
      ST_SET_HR:  if (bus.mode_pulse) state_nx = ST_SET_MIN;
                  else if (to_hit)    state_nx = ST_RUN;
      ST_SET_MIN: if (bus.mode_pulse || to_hit) state_nx = ST_RUN;
      default:    state_nx = ST_RUN;
    endcase
  end

  assign state_chg = (state_nx != state);

  auto_repeat_gen #(
    .CNT_W(CNT_W), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
  ) u_up_rep (
    .clk(clk), .rst_n(rst_n), .tick(bus.tick), .held(bus.up_held),
    .enable(in_set && !state_chg && !bus.down_held), .strobe(up_rep)
  );

  auto_repeat_gen #(
    .CNT_W(CNT_W), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
  ) u_dn_rep (
    .clk(clk), .rst_n(rst_n), .tick(bus.tick), .held(bus.down_held),
    .enable(in_set && !state_chg && !bus.up_held), .strobe(dn_rep)
  );

  // Opposing requests in the same clk cancel so at most one strobe is ever issued.
  assign up_req = (in_set && !state_chg && bus.up_pulse && !bus.down_pulse) || up_rep;
  assign dn_req = (in_set && !state_chg && bus.down_pulse && !bus.up_pulse) || dn_rep;
  assign go_up  = up_req && !dn_req;
  assign go_dn  = dn_req && !up_req;

  assign bus.set_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.run_en   <= 1'b1;
      bus.sec_clr  <= 1'b0;
      bus.hour_inc <= 1'b0;
      bus.hour_dec <= 1'b0;
      bus.min_inc  <= 1'b0;
      bus.min_dec  <= 1'b0;
      bus.blink_on <= 1'b1;
      to_cnt       <= '0;
      bl_cnt       <= '0;
    end else begin
      bus.run_en   <= (state_nx == ST_RUN);
      bus.sec_clr  <= (state == ST_RUN) && (state_nx == ST_SET_HR);
      bus.hour_inc <= go_up && (state == ST_SET_HR);
      bus.hour_dec <= go_dn && (state == ST_SET_HR);
      bus.min_inc  <= go_up && (state == ST_SET_MIN);
      bus.min_dec  <= go_dn && (state == ST_SET_MIN);

      if (state_chg || !in_set || any_pulse) to_cnt <= '0;
      else if (bus.tick)                     to_cnt <= to_inc;

      if (state_chg || !in_set || go_up || go_dn) begin
        bl_cnt       <= '0;
        bus.blink_on <= 1'b1;
      end else if (bus.tick) begin
        if (bl_inc >= CNT_W'(BLINK_TICKS)) begin
          bl_cnt       <= '0;
          bus.blink_on <= !bus.blink_on;
        end else begin
          bl_cnt       <= bl_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - scoreboard bench for clock_set_ctrl against a tick-counting reference model
module tb_clock_set_ctrl;

  localparam int D = 5;
  localparam int R = 2;
  localparam int T = 20;
  localparam int B = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clock_set_ctrl_if bus ();

  clock_set_ctrl #(
    .CNT_W(10), .REPEAT_DELAY(D), .REPEAT_RATE(R), .TIMEOUT_TICKS(T), .BLINK_TICKS(B)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int pushed = 0;
  int popped = 0;
  logic [8:0] exp_q[$];

  // Reference model: state 0/1/2 plus elapsed-tick counts since each relevant event.
  int m_state, up_n, dn_n, idle_n, bl_n;
  bit r_uh, r_dh;

  // {run_en, sec_clr, hour_inc, hour_dec, min_inc, min_dec, blink_on, set_state}
  function automatic logic [8:0] actual();
    return {bus.run_en, bus.sec_clr, bus.hour_inc, bus.hour_dec,
            bus.min_inc, bus.min_dec, bus.blink_on, bus.set_state};
  endfunction

  function automatic bit rep_due(input int n);
    return (n == D) || ((n > D) && ((n - D) % R == 0));
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; up_n = 0; dn_n = 0; idle_n = 0; bl_n = 0;
  endtask

  task automatic model_step(input bit tk, md, up, dn, uh, dh, output logic [8:0] e);
    bit in_set, chg, any, up_fire, dn_fire, up_w, dn_w, hi, hd, mi, mdc;
    int nxt;
    in_set = (m_state != 0);
    any    = md || up || dn;
    nxt    = m_state;
    if (md) nxt = (m_state + 1) % 3;
    else if (in_set && tk && !any && (idle_n + 1 >= T)) nxt = 0;
    chg = (nxt != m_state);

    up_fire = 0;
    dn_fire = 0;
    if (in_set && !chg && uh && !dh) begin
      if (tk) begin up_n++; up_fire = rep_due(up_n); end
    end else up_n = 0;
    if (in_set && !chg && dh && !uh) begin
      if (tk) begin dn_n++; dn_fire = rep_due(dn_n); end
    end else dn_n = 0;

    up_w = (in_set && !chg && up && !dn) || up_fire;
    dn_w = (in_set && !chg && dn && !up) || dn_fire;
    hi   = up_w && !dn_w && (m_state == 1);
    hd   = dn_w && !up_w && (m_state == 1);
    mi   = up_w && !dn_w && (m_state == 2);
    mdc  = dn_w && !up_w && (m_state == 2);

    if (chg || !in_set || any) idle_n = 0;
    else if (tk)               idle_n++;
    if (chg || !in_set || hi || hd || mi || mdc) bl_n = 0;
    else if (tk)                                 bl_n++;

    e = {(nxt == 0), (m_state == 0) && (nxt == 1), hi, hd, mi, mdc,
         ((bl_n / B) % 2 == 0), 2'(nxt)};
    m_state = nxt;
  endtask

  task automatic cyc(input bit tk, md, up, dn, uh, dh);
    logic [8:0] e;
    @(negedge clk);
    bus.tick = tk; bus.mode_pulse = md; bus.up_pulse = up;
    bus.down_pulse = dn; bus.up_held = uh; bus.down_held = dh;
    model_step(tk, md, up, dn, uh, dh, e);
    exp_q.push_back(e);
    pushed++;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic ticks(input int n, input bit uh, input bit dh);
    repeat (n) begin
      cyc(1, 0, 0, 0, uh, dh);
      cyc(0, 0, 0, 0, uh, dh);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        check("outputs", actual(), exp_q.pop_front());
        popped++;
      end
    end
  end

  initial begin
    bus.tick = 0; bus.mode_pulse = 0; bus.up_pulse = 0;
    bus.down_pulse = 0; bus.up_held = 0; bus.down_held = 0;
    model_reset();
    #12;
    check("reset_power_on", actual(), 9'b1_0_0000_1_00);
    @(negedge clk);
    rst_n = 1'b1;

    idle(3);
    cyc(0, 1, 0, 0, 0, 0); idle(2);
    cyc(0, 1, 0, 0, 0, 0); idle(2);
    cyc(0, 1, 0, 0, 0, 0); idle(2);

    cyc(0, 1, 0, 0, 0, 0); idle(1);
    cyc(0, 0, 1, 0, 0, 0); idle(1);
    cyc(0, 1, 1, 0, 0, 0); idle(1);
    cyc(0, 0, 1, 1, 0, 0); idle(1);

    ticks(11, 1, 0);
    ticks(4, 0, 0);
    ticks(7, 0, 1);
    ticks(3, 1, 1);
    cyc(0, 1, 0, 0, 0, 0); idle(1);

    cyc(0, 1, 0, 0, 0, 0);
    ticks(T + 3, 0, 0);

    cyc(0, 1, 0, 0, 0, 0);
    ticks(7, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    ticks(4, 0, 0);

    cyc(0, 1, 0, 0, 0, 0);
    ticks(2, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_mid_edit", actual(), 9'b1_0_0000_1_00);
    bus.tick = 0; bus.mode_pulse = 0; bus.up_pulse = 0;
    bus.down_pulse = 0; bus.up_held = 0; bus.down_held = 0;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    idle(2);

    r_uh = 0;
    r_dh = 0;
    for (int ph = 0; ph < 2; ph++) begin
      repeat (3000) begin
        if ($urandom_range(0, 15) == 0) r_uh = !r_uh;
        if ($urandom_range(0, 15) == 0) r_dh = !r_dh;
        cyc($urandom_range(0, 2) == 0,
            $urandom_range(0, ph ? 30 : 120) == 0,
            $urandom_range(0, ph ? 12 : 90) == 0,
            $urandom_range(0, ph ? 12 : 90) == 0,
            r_uh, r_dh);
      end
    end
    idle(2);
    @(negedge clk);

    checks++;
    if (exp_q.size() != 0 || popped != pushed) begin
      errors++;
      $display("FAIL drain popped=%0d pushed=%0d", popped, pushed);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
